// File: rtl/fft_bin_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_bin_sequencer_if : frame input, bin stream and peak report bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fft_bin_sequencer_if #(
  parameter int NBINS = 16,
  parameter int DW    = 32,
  parameter int IDXW  = 4
);
  logic                frame_valid;
  logic [NBINS*DW-1:0] frame_data;
  logic                frame_busy;
  logic                bin_valid;
  logic                bin_ready;
  logic [DW-1:0]       bin_data;
  logic [IDXW-1:0]     bin_idx;
  logic                bin_last;
  logic                peak_valid;
  logic [IDXW-1:0]     peak_idx;
  logic [DW-1:0]       peak_val;
  logic [7:0]          drop_cnt;

  // The sequencer side: sources the bin stream and peak report
  modport master (
    input  frame_valid, frame_data, bin_ready,
    output frame_busy, bin_valid, bin_data, bin_idx, bin_last,
           peak_valid, peak_idx, peak_val, drop_cnt
  );

  // The environment side: supplies frames and consumes bins
  modport slave (
    output frame_valid, frame_data, bin_ready,
    input  frame_busy, bin_valid, bin_data, bin_idx, bin_last,
           peak_valid, peak_idx, peak_val, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fft_bin_sequencer.sv
// ---------------------------------------------------------------------------
// fft_bin_sequencer : buffers one FFT frame, streams its bins, reports peak
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fft_bin_sequencer #(
  parameter int NBINS = 16,
  parameter int DW    = 32,
  parameter int IDXW  = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  fft_bin_sequencer_if.master bin_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   buf_q [NBINS];
  logic [DW-1:0]   buf_d [NBINS];
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] run_idx_q, run_idx_d;
  logic [DW-1:0]   run_val_q, run_val_d;
  logic [IDXW-1:0] peak_idx_q, peak_idx_d;
  logic [DW-1:0]   peak_val_q, peak_val_d;
  logic [7:0]      drop_q, drop_d;

  logic [DW-1:0]   w_cur;
  logic            w_last;
  logic            w_better;

  assign w_cur    = buf_q[idx_q];
  assign w_last   = (idx_q == IDXW'(NBINS - 1));
  // Strict compare keeps the earliest index on ties; bin 0 always seeds the peak
  assign w_better = (idx_q == '0) || (w_cur > run_val_q);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    run_idx_d  = run_idx_q;
    run_val_d  = run_val_q;
    peak_idx_d = peak_idx_q;
    peak_val_d = peak_val_q;
    drop_d     = drop_q;

    if (bin_if.frame_valid && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (bin_if.frame_valid) begin
          for (int k = 0; k < NBINS; k++) begin
            buf_d[k] = bin_if.frame_data[k*DW +: DW];
          end
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bin_if.bin_ready) begin
          if (w_better) begin
            run_idx_d = idx_q;
            run_val_d = w_cur;
          end
          if (w_last) begin
            // Publish the peak including this final bin's comparison
            peak_idx_d = w_better ? idx_q : run_idx_q;
            peak_val_d = w_better ? w_cur : run_val_q;
            state_d    = S_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      run_idx_q  <= '0;
      run_val_q  <= '0;
      peak_idx_q <= '0;
      peak_val_q <= '0;
      drop_q     <= '0;
      for (int k = 0; k < NBINS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_idx_q  <= run_idx_d;
      run_val_q  <= run_val_d;
      peak_idx_q <= peak_idx_d;
      peak_val_q <= peak_val_d;
      drop_q     <= drop_d;
      for (int k = 0; k < NBINS; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign bin_if.frame_busy = (state_q != S_IDLE);
  assign bin_if.bin_valid  = (state_q == S_STREAM);
  assign bin_if.bin_data   = (state_q == S_STREAM) ? w_cur : '0;
  assign bin_if.bin_idx    = idx_q;
  assign bin_if.bin_last   = (state_q == S_STREAM) && w_last;
  assign bin_if.peak_valid = (state_q == S_DONE);
  assign bin_if.peak_idx   = peak_idx_q;
  assign bin_if.peak_val   = peak_val_q;
  assign bin_if.drop_cnt   = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_bin_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_bin_sequencer : directed + randomized checks against a frame-level model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fft_bin_sequencer;
  localparam int NBINS = 16;
  localparam int DW    = 32;
  localparam int IDXW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_bin_sequencer_if #(.NBINS(NBINS), .DW(DW), .IDXW(IDXW)) bif ();

  fft_bin_sequencer #(.NBINS(NBINS), .DW(DW), .IDXW(IDXW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bin_if (bif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int model_drop  = 0;
  logic [DW-1:0] frm [NBINS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bin_valid"},  64'(bif.bin_valid),  64'd0);
    check({tag, "_bin_last"},   64'(bif.bin_last),   64'd0);
    check({tag, "_peak_valid"}, 64'(bif.peak_valid), 64'd0);
    check({tag, "_frame_busy"}, 64'(bif.frame_busy), 64'd0);
    check({tag, "_bin_idx"},    64'(bif.bin_idx),    64'd0);
    check({tag, "_bin_data"},   64'(bif.bin_data),   64'd0);
    check({tag, "_peak_idx"},   64'(bif.peak_idx),   64'd0);
    check({tag, "_peak_val"},   64'(bif.peak_val),   64'd0);
    check({tag, "_drop_cnt"},   64'(bif.drop_cnt),   64'd0);
  endtask

  // Peak = largest magnitude; among equals, the first position holding it
  task automatic ref_peak(output int pi, output logic [DW-1:0] pv);
    pv = '0;
    for (int i = 0; i < NBINS; i++) if (frm[i] > pv) pv = frm[i];
    pi = 0;
    for (int i = NBINS - 1; i >= 0; i--) if (frm[i] == pv) pi = i;
  endtask

  task automatic garbage();
    for (int i = 0; i < NBINS; i++) bif.frame_data[i*DW +: DW] = $urandom();
  endtask

  task automatic note_drop();
    if (model_drop < 255) model_drop++;
  endtask

  // mode 0: ready always 1, 1: ready = 1,0,0 repeating, 2: random ready
  task automatic run_frame(input int mode, input logic [15:0] drop_mask, input bit drop_done);
    int pi, k, c, lastk;
    logic [DW-1:0] pv;
    logic rdy;
    ref_peak(pi, pv);
    for (int i = 0; i < NBINS; i++) bif.frame_data[i*DW +: DW] = frm[i];
    bif.frame_valid = 1'b1;
    bif.bin_ready   = 1'b1;
    tick();
    bif.frame_valid = 1'b0;
    garbage();
    k = 0; c = 0; lastk = -1;
    while (k < NBINS && c < 2000) begin
      check("bin_valid",  64'(bif.bin_valid),  64'd1);
      check("bin_idx",    64'(bif.bin_idx),    64'(k));
      check("bin_data",   64'(bif.bin_data),   64'(frm[k]));
      check("bin_last",   64'(bif.bin_last),   64'(k == NBINS - 1));
      check("peak_quiet", 64'(bif.peak_valid), 64'd0);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((c % 3) == 0) : 1'($urandom_range(0, 1));
      bif.bin_ready = rdy;
      if (drop_mask[k] && k != lastk) begin
        bif.frame_valid = 1'b1;
        garbage();
        note_drop();
        lastk = k;
      end else begin
        bif.frame_valid = 1'b0;
      end
      tick();
      if (rdy) k++;
      c++;
    end
    bif.frame_valid = 1'b0;
    if (c >= 2000) check("stream_timeout", 64'd1, 64'd0);
    check("done_peak_valid", 64'(bif.peak_valid), 64'd1);
    check("done_bin_valid",  64'(bif.bin_valid),  64'd0);
    check("done_busy",       64'(bif.frame_busy), 64'd1);
    check("peak_idx",        64'(bif.peak_idx),   64'(pi));
    check("peak_val",        64'(bif.peak_val),   64'(pv));
    if (drop_done) begin
      bif.frame_valid = 1'b1;
      garbage();
      note_drop();
    end
    bif.bin_ready = 1'($urandom_range(0, 1));
    tick();
    bif.frame_valid = 1'b0;
    check("idle_peak_valid", 64'(bif.peak_valid), 64'd0);
    check("idle_busy",       64'(bif.frame_busy), 64'd0);
    check("idle_bin_valid",  64'(bif.bin_valid),  64'd0);
    check("idle_drop_cnt",   64'(bif.drop_cnt),   64'(model_drop));
    check("held_peak_idx",   64'(bif.peak_idx),   64'(pi));
    check("held_peak_val",   64'(bif.peak_val),   64'(pv));
  endtask

  initial begin
    int w;
    rst = 1'b1;
    bif.frame_valid = 1'b0;
    bif.frame_data  = '0;
    bif.bin_ready   = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("post_reset");

    // Ramp frame, ready held high, then the 1,0,0 ready pattern
    for (int i = 0; i < NBINS; i++) frm[i] = 32'(i * 16);
    run_frame(0, 16'h0000, 1'b0);
    check("ramp_peak_idx", 64'(bif.peak_idx), 64'd15);
    check("ramp_peak_val", 64'(bif.peak_val), 64'hF0);
    run_frame(1, 16'h0000, 1'b0);

    // Ties keep the lowest index
    for (int i = 0; i < NBINS; i++) frm[i] = 32'd1;
    frm[0] = 32'h8000_0000;
    frm[3] = 32'hFFFF_FFFF;
    frm[9] = 32'hFFFF_FFFF;
    run_frame(2, 16'h0000, 1'b0);
    check("tie_peak_idx", 64'(bif.peak_idx), 64'd3);

    // Drops during bins 2 and 5 and in the DONE cycle
    for (int i = 0; i < NBINS; i++) frm[i] = $urandom();
    run_frame(0, 16'h0024, 1'b1);
    check("drop_cnt_3", 64'(bif.drop_cnt), 64'd3);

    // Continuous frame_valid drives the drop counter into saturation
    for (int i = 0; i < 300; i++) begin
      bif.frame_valid = 1'b1;
      bif.bin_ready   = 1'b1;
      garbage();
      tick();
    end
    bif.frame_valid = 1'b0;
    w = 0;
    while (bif.frame_busy && w < 40) begin
      tick();
      w++;
    end
    check("sat_settle", 64'(bif.frame_busy), 64'd0);
    check("drop_sat", 64'(bif.drop_cnt), 64'd255);
    model_drop = 255;

    // Reset while bin 7 is presented
    for (int i = 0; i < NBINS; i++) frm[i] = $urandom();
    for (int i = 0; i < NBINS; i++) bif.frame_data[i*DW +: DW] = frm[i];
    bif.frame_valid = 1'b1;
    bif.bin_ready   = 1'b1;
    tick();
    bif.frame_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("pre_rst_idx", 64'(bif.bin_idx), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_drop = 0;
    check_zero("midrst");
    for (int i = 0; i < 25; i++) begin
      check("midrst_no_peak", 64'(bif.peak_valid), 64'd0);
      tick();
    end
    run_frame(2, 16'h0000, 1'b0);

    // Extremes
    for (int i = 0; i < NBINS; i++) frm[i] = '0;
    run_frame(0, 16'h0000, 1'b0);
    check("zero_peak_idx", 64'(bif.peak_idx), 64'd0);
    frm[15] = 32'h0000_0001;
    run_frame(2, 16'h0000, 1'b0);
    check("last_peak_idx", 64'(bif.peak_idx), 64'd15);

    // Random frames with narrow value range to provoke ties, random drops
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NBINS; i++) frm[i] = 32'($urandom_range(0, 7));
      run_frame(2, 16'($urandom()), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_bin_sequencer.md
Name: fft_bin_sequencer

Overview:
Controller that accepts one parallel FFT frame of NBINS bins from the registered FFT output stage. It streams the bins one at a time to a shared downstream analysis datapath over a valid/ready handshake. While streaming, it tracks the peak-magnitude bin and reports it once per frame. Frames that arrive while it is busy are dropped and counted, so upstream never needs backpressure.

Parameters:
NBINS, 16, number of bins per frame (power of two, >=2)
DW, 32, bin width; bins are treated as unsigned magnitudes
IDXW, 4, bin index width, equal to log2(NBINS)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_valid  in  1  one-cycle pulse; frame_data is valid this cycle
frame_data  in  NBINS*DW  bin k is at [k*DW +: DW]
frame_busy  out  1  high while a frame is held (state != IDLE)
bin_valid  out  1  streamed bin is valid
bin_ready  in  1  downstream accepts the bin
bin_data  out  DW  current bin value
bin_idx  out  IDXW  current bin index
bin_last  out  1  high with bin_valid when bin_idx == NBINS-1
peak_valid  out  1  one-cycle pulse when frame peak is final
peak_idx  out  IDXW  index of max bin, held until next peak_valid
peak_val  out  DW  value of max bin, held until next peak_valid
drop_cnt  out  8  saturating count of dropped frames

Behaviour:
- Reset (clk edge with rst=1):
  - state goes to IDLE.
  - All outputs are 0: bin_valid, bin_last, peak_valid, frame_busy, bin_idx, bin_data, peak_idx, peak_val, drop_cnt.
  - Frame buffer and running-peak registers are cleared to 0.
  - rst overrides all other inputs on the same edge.
- FSM states are IDLE, STREAM and DONE.
- IDLE:
  - frame_valid=1 captures all NBINS bins into the internal buffer, sets idx=0 and moves to STREAM.
  - bin_valid is first high in the cycle after frame_valid (latency 1).
- STREAM:
  - bin_valid=1; bin_data=buf[idx]; bin_idx=idx; bin_last=(idx==NBINS-1).
  - A handshake occurs when bin_valid and bin_ready are both 1 at a clk edge.
  - On handshake with idx<NBINS-1: idx increments.
  - On handshake with idx==NBINS-1: go to DONE.
  - With bin_ready=0, bin_data, bin_idx and bin_last must stay stable; no bin is skipped or repeated.
- Peak tracking, on each handshake:
  - idx==0 loads running peak = (0, buf[0]).
  - Otherwise the running peak is replaced only if buf[idx] > running value (unsigned, strict). Ties therefore keep the lowest index.
- DONE (lasts exactly one cycle):
  - bin_valid=0 and peak_valid=1.
  - peak_idx and peak_val show the final running peak, and are updated on the edge entering DONE.
  - Next state is IDLE.
- frame_busy = (state != IDLE).
- Drops:
  - frame_valid while in STREAM or DONE discards that frame; the buffer and stream are unaffected.
  - drop_cnt increments by 1 per dropped frame and saturates at 255.
  - drop_cnt clears only on rst.
- Minimum frame period without drops is NBINS+2 cycles when bin_ready is held 1.
- Reset mid-frame abandons the frame: no peak_valid, and peak_idx/peak_val return to 0.

Test Plan:
- Frame with bin k = k*0x10, pulsed at cycle T, bin_ready=1 throughout:
  - bins 0..15 appear on cycles T+1..T+16, with bin_last only at T+16;
  - peak_valid at T+17 with peak_idx=15, peak_val=0xF0;
  - frame_busy low at T+18.
- Same frame with bin_ready following the pattern 1,0,0,1,0,... :
  - bin_data and bin_idx stay stable while ready=0;
  - all 16 bins are delivered in order exactly once;
  - peak is reported one cycle after the last handshake.
- Tie and ordering: bins 3 and 9 = 0xFFFFFFFF, bin 0 = 0x80000000, others 1 -> peak_idx=3, peak_val=0xFFFFFFFF.
- Drops:
  - frame_valid pulsed during bins 2, 5 and in the DONE cycle -> drop_cnt=3, and the streamed data equals the first frame;
  - 300 back-to-back frame_valid pulses -> drop_cnt saturates at 255.
- Reset during STREAM at bin_idx=7 -> next cycle all outputs are 0 and no peak_valid ever follows; a new frame afterwards streams from index 0 with a correct peak.
- Single-bin extremes: all bins 0 -> peak_idx=0, peak_val=0; only bin 15 nonzero -> peak_idx=15.
